fetchbuffer: RTL and testbench

Instruction prefetch stage between a variable-latency program memory and the pipelined datapath's IF-ID register. Holds a program counter and issues one outstanding request/acknowledge fetch at a time. Queues returned instructions with their PCs in a small FIFO and presents the head to IF-ID. Flushes queue and in-flight fetch on a taken-branch redirect from the write-back stage.

---
 rtl/fetchbuffer_pkg.sv | 14 +
 rtl/fetchbuffer_instqueue.sv | 56 +++++
 rtl/fetchbuffer.sv | 101 ++++++++++
 tb/tb_fetchbuffer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetchbuffer_pkg.sv
// Shared widths, fetch controller state encoding and PC step for the prefetch stage.
package fetchbuffer_pkg;

  localparam int BUS_WORDSIZE = 64;
  localparam int BUS_INSTSIZE = 32;
  localparam int PC_INC       = 4;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'b00,
    FETCH_WAIT = 2'b01,
    FETCH_DROP = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/fetchbuffer_instqueue.sv
// DEPTH-entry synchronous FIFO of {pc, inst}; head is read combinationally from storage.
module instqueue
  import fetchbuffer_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int PW    = BUS_WORDSIZE,
  parameter  int IW    = BUS_INSTSIZE,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [PW-1:0] push_pc,
  input  logic [IW-1:0] push_inst,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic          head_valid,
  output logic [PW-1:0] head_pc,
  output logic [IW-1:0] head_inst
);

  logic [DEPTH-1:0][PW-1:0] pc_mem;
  logic [DEPTH-1:0][IW-1:0] inst_mem;
  logic [AW-1:0]            rd_ptr, wr_ptr;

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      pc_mem[wr_ptr]   <= push_pc;
      inst_mem[wr_ptr] <= push_inst;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_valid = (count != '0);
  assign head_pc    = head_valid ? pc_mem[rd_ptr]   : '0;
  assign head_inst  = head_valid ? inst_mem[rd_ptr] : '0;

endmodule

// File: rtl/fetchbuffer.sv
// Instruction prefetch: one outstanding req/ack fetch, queued results, redirect flush.
module fetchbuffer
  import fetchbuffer_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int WORDSIZE = BUS_WORDSIZE,
  parameter int INSTSIZE = BUS_INSTSIZE
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [WORDSIZE-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [INSTSIZE-1:0] imem_data,
  input  logic                stall,
  input  logic                redirect,
  input  logic [WORDSIZE-1:0] redirect_pc,
  output logic                out_valid,
  output logic [WORDSIZE-1:0] out_pc,
  output logic [INSTSIZE-1:0] out_inst
);

  localparam int            CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  fetch_state_e        state, state_n;
  logic [WORDSIZE-1:0] fetch_pc, pc_n, addr_n, target;
  logic                push, pop;
  logic [CW-1:0]       count;

  assign target   = redirect_pc & ~WORDSIZE'(3);
  assign pop      = out_valid && !stall && !redirect;
  assign imem_req = (state != FETCH_IDLE);

  always_comb begin
    state_n = state;
    pc_n    = fetch_pc;
    addr_n  = imem_addr;
    push    = 1'b0;
    case (state)
      // A redirect empties the queue, so the new target can be requested at once.
      FETCH_IDLE: begin
        if (redirect) begin
          pc_n    = target;
          state_n = FETCH_WAIT;
        end else if (count != FULL) begin
          state_n = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (redirect) begin
          pc_n    = target;
          state_n = imem_ack ? FETCH_WAIT : FETCH_DROP;
        end else if (imem_ack) begin
          push    = 1'b1;
          pc_n    = fetch_pc + WORDSIZE'(PC_INC);
          state_n = (pop || count != LAST) ? FETCH_WAIT : FETCH_IDLE;
        end
      end
      // Abandoned request stays on the bus until its ack drains.
      FETCH_DROP: begin
        if (redirect) pc_n = target;
        if (imem_ack) state_n = FETCH_IDLE;
      end
      default: state_n = FETCH_IDLE;
    endcase
    if (state_n == FETCH_WAIT) addr_n = pc_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH_IDLE;
      fetch_pc  <= '0;
      imem_addr <= '0;
    end else begin
      state     <= state_n;
      fetch_pc  <= pc_n;
      imem_addr <= addr_n;
    end
  end

  instqueue #(
    .DEPTH (DEPTH),
    .PW    (WORDSIZE),
    .IW    (INSTSIZE)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .clear      (redirect),
    .push       (push),
    .push_pc    (fetch_pc),
    .push_inst  (imem_data),
    .pop        (pop),
    .count      (count),
    .head_valid (out_valid),
    .head_pc    (out_pc),
    .head_inst  (out_inst)
  );

endmodule

// File: tb/tb_fetchbuffer.sv
// Randomized bench for fetchbuffer against a queue-level reference model plus directed scenarios.
module tb_fetchbuffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic        stall = 1'b0;
  logic        redirect_in = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_inst;

  fetchbuffer #(.DEPTH(DEPTH), .WORDSIZE(64), .INSTSIZE(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .stall       (stall),
    .redirect    (redirect_in),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_inst    (out_inst)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: queue of PCs in program order, next fetch PC, drop tracking
  logic [63:0] q[$];
  logic [63:0] m_pc;
  logic [63:0] drop_addr;
  bit          dropping;

  // memory model
  int fixed_lat;  // <0 means random latency per transaction
  int lat;
  int wcnt;
  int ack_cnt;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  // Called at the negedge: respond to whatever request the DUT presents.
  task automatic mem_drive();
    if (imem_req) begin
      if (wcnt >= lat) begin
        imem_ack  = 1'b1;
        imem_data = mem_word(imem_addr);
        wcnt      = 0;
        ack_cnt++;
        lat = (fixed_lat < 0) ? int'($urandom_range(0, 3)) : fixed_lat;
      end else begin
        imem_ack  = 1'b0;
        imem_data = $urandom;
        wcnt++;
      end
    end else begin
      imem_ack = 1'b0;
      wcnt     = 0;
    end
  endtask

  // Check outputs against the model, cross the rising edge, advance the model.
  task automatic finish_cycle();
    logic req_s;
    logic [63:0] addr_s;
    bit acc, pop_m;
    req_s  = imem_req;
    addr_s = imem_addr;
    chk("out_valid", out_valid, 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_pc", out_pc, q[0]);
      chk("out_inst", 64'(out_inst), 64'(mem_word(q[0])));
    end
    if (imem_req && !dropping) chk("imem_addr", imem_addr, m_pc);
    if (imem_req && dropping)  chk("drop_addr", imem_addr, drop_addr);
    chk("count", 64'(dut.u_queue.count), 64'(q.size()));
    chk("count_bound", 64'(dut.u_queue.count <= DEPTH), 64'd1);
    acc   = imem_ack && !dropping && !redirect_in;
    pop_m = (q.size() != 0) && !stall && !redirect_in;
    @(posedge clk);
    if (redirect_in) begin
      q.delete();
      m_pc = redirect_pc & ~64'h3;
    end else begin
      if (pop_m) void'(q.pop_front());
      if (acc) begin
        q.push_back(m_pc);
        m_pc = m_pc + 64'd4;
      end
    end
    if (imem_ack) dropping = 1'b0;
    if (redirect_in && req_s && !imem_ack) begin
      if (!dropping) drop_addr = addr_s;
      dropping = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic step();
    mem_drive();
    finish_cycle();
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    redirect_in = 1'b0;
    imem_ack    = 1'b0;
    wcnt        = 0;
    lat         = (fixed_lat < 0) ? 0 : fixed_lat;
    repeat (2) @(negedge clk);
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_addr", imem_addr, 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_pc", out_pc, 64'd0);
    chk("rst_inst", 64'(out_inst), 64'd0);
    q.delete();
    m_pc     = '0;
    dropping = 1'b0;
    rst      = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found, seen10, seen40;

    // 1/2: zero-latency memory, no stall: pcs 0,4,8,12 from cycle 2
    fixed_lat = 0;
    stall     = 1'b0;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      mem_drive();
      if (c == 0) chk("t2_c0_req", 64'(imem_req), 64'd0);
      if (c == 1) begin
        chk("t2_c1_req", 64'(imem_req), 64'd1);
        chk("t2_c1_addr", imem_addr, 64'd0);
      end
      if (c >= 2 && c <= 5) begin
        chk("t2_valid", 64'(out_valid), 64'd1);
        chk("t2_pc", out_pc, 64'(4 * (c - 2)));
        chk("t2_inst", 64'(out_inst), 64'(mem_word(64'(4 * (c - 2)))));
      end
      finish_cycle();
    end

    // 3: stall from reset fills the queue then the request drops
    stall = 1'b1;
    do_reset();
    ack_cnt = 0;
    repeat (20) step();
    chk("t3_acks", 64'(ack_cnt), 64'd4);
    chk("t3_req", 64'(imem_req), 64'd0);
    chk("t3_count", 64'(dut.u_queue.count), 64'd4);
    chk("t3_head_pc", out_pc, 64'd0);

    // 4: release stall, next request is pc 16
    stall = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      mem_drive();
      if (imem_req && !found) begin
        found = 1'b1;
        chk("t4_next_req", imem_addr, 64'd16);
      end
      finish_cycle();
    end
    chk("t4_req_seen", 64'(found), 64'd1);

    // 5: latency 3, redirect the cycle after the request for 0x8 appears
    fixed_lat = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      mem_drive();
      if (imem_req && imem_addr == 64'h8) found = 1'b1;
      finish_cycle();
    end
    chk("t5_req8_seen", 64'(found), 64'd1);
    redirect_in = 1'b1;
    redirect_pc = 64'h103;
    mem_drive();
    finish_cycle();
    redirect_in = 1'b0;
    chk("t5_drop_req", 64'(imem_req), 64'd1);
    chk("t5_drop_addr", imem_addr, 64'h8);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      mem_drive();
      if (imem_req && imem_addr != 64'h8) begin
        found = 1'b1;
        chk("t5_next_addr", imem_addr, 64'h100);
      end
      finish_cycle();
    end
    chk("t5_next_seen", 64'(found), 64'd1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (out_valid) begin
        found = 1'b1;
        chk("t5_first_out", out_pc, 64'h100);
      end
      step();
    end
    chk("t5_out_seen", 64'(found), 64'd1);

    // 6: redirect to 0x40 in the same cycle as the ack for 0x10
    fixed_lat = 1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      mem_drive();
      if (imem_ack && imem_addr == 64'h10) begin
        redirect_in = 1'b1;
        redirect_pc = 64'h40;
        found       = 1'b1;
      end
      finish_cycle();
      redirect_in = 1'b0;
    end
    chk("t6_ack10_seen", 64'(found), 64'd1);
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_req", 64'(imem_req), 64'd1);
    chk("t6_addr", imem_addr, 64'h40);
    seen10 = 1'b0;
    seen40 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid && out_pc == 64'h10) seen10 = 1'b1;
      if (out_valid && out_pc == 64'h40) seen40 = 1'b1;
      step();
    end
    chk("t6_seen_0x10", 64'(seen10), 64'd0);
    chk("t6_seen_0x40", 64'(seen40), 64'd1);

    // 7: asynchronous reset mid-WAIT with 2 entries queued
    fixed_lat = 2;
    stall     = 1'b1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (q.size() == 2 && imem_req) found = 1'b1;
      else step();
    end
    chk("t7_two_queued", 64'(found), 64'd1);
    imem_ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t7_async_req", 64'(imem_req), 64'd0);
    chk("t7_async_addr", imem_addr, 64'd0);
    chk("t7_async_valid", 64'(out_valid), 64'd0);
    chk("t7_async_pc", out_pc, 64'd0);
    chk("t7_async_inst", 64'(out_inst), 64'd0);
    stall     = 1'b0;
    fixed_lat = 0;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      mem_drive();
      if (c == 1) begin
        chk("t7_restart_req", 64'(imem_req), 64'd1);
        chk("t7_restart_addr", imem_addr, 64'd0);
      end
      finish_cycle();
    end

    // 8: random latency, stall and redirect traffic, including PC wrap
    fixed_lat = -1;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      stall = ($urandom_range(0, 99) < 30);
      mem_drive();
      redirect_in = ($urandom_range(0, 99) < 5);
      if (redirect_in)
        redirect_pc = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF6 : {$urandom, $urandom};
      finish_cycle();
      redirect_in = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
